// File: rtl/aes_stream_adapter_pkg.sv
// Shared types, constants and helpers for the AES stream adapter.
// Optional feature macro: AES_ADAPTER_BYTESWAP_EN (per-word byte reversal).
package aes_package;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_WORD_W  = 32;

  typedef enum logic {
    PK_FILL,
    PK_HOLD
  } pk_state_t;

  typedef enum logic {
    UP_IDLE,
    UP_DRAIN
  } up_state_t;

  // Reverse byte order of one streamer word.
  function automatic logic [AES_WORD_W-1:0] byte_swap(input logic [AES_WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_stream_adapter_if.sv
// Handshake bundle between the word streamers, the adapter and the AES core.
// slave = adapter view, master = environment view.
interface aes_stream_adapter_if
  import aes_package::*;
#(
  parameter int unsigned WORD_W = AES_WORD_W,
  parameter int unsigned WORDS  = AES_BLOCK_W / AES_WORD_W
);

  logic [WORD_W-1:0]       pt_data_i;
  logic                    pt_valid_i;
  logic                    pt_ready_o;
  logic [WORD_W*WORDS-1:0] blk_data_o;
  logic                    blk_valid_o;
  logic                    blk_ready_i;
  logic [WORD_W*WORDS-1:0] ct_data_i;
  logic                    ct_valid_i;
  logic                    ct_ready_o;
  logic [WORD_W-1:0]       ctw_data_o;
  logic                    ctw_valid_o;
  logic                    ctw_ready_i;

  modport slave (
    input  pt_data_i, pt_valid_i, blk_ready_i, ct_data_i, ct_valid_i, ctw_ready_i,
    output pt_ready_o, blk_data_o, blk_valid_o, ct_ready_o, ctw_data_o, ctw_valid_o
  );

  modport master (
    output pt_data_i, pt_valid_i, blk_ready_i, ct_data_i, ct_valid_i, ctw_ready_i,
    input  pt_ready_o, blk_data_o, blk_valid_o, ct_ready_o, ctw_data_o, ctw_valid_o
  );

endinterface

// File: rtl/aes_unpacker.sv
// Ciphertext unpacker: takes one 128-bit block, drains it as words (lane 0 first),
// counts drained blocks and pulses done when the job count is reached.
// Optional feature macro: AES_ADAPTER_BYTESWAP_EN (byte-reverse each output word).
module aes_unpacker
  import aes_package::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [15:0]             n_blocks_i,
  input  logic [WORD_W*WORDS-1:0] ct_data_i,
  input  logic                    ct_valid_i,
  output logic                    ct_ready_o,
  output logic [WORD_W-1:0]       ctw_data_o,
  output logic                    ctw_valid_o,
  input  logic                    ctw_ready_i,
  output logic [15:0]             blk_cnt_o,
  output logic                    done_o
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  up_state_t               r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [WORD_W*WORDS-1:0] r_blk;
  // 17 bits so that n_blocks_i == 0 (65536 blocks) is reachable.
  logic [16:0]             r_cnt;
  logic                    r_done;

  logic [16:0]       w_target;
  logic [16:0]       w_cnt_inc;
  logic              w_full;
  logic              w_ct_fire;
  logic              w_ctw_fire;
  logic [WORD_W-1:0] w_lane;

  assign w_target   = {(n_blocks_i == 16'd0), n_blocks_i};
  assign w_cnt_inc  = r_cnt + 17'd1;
  assign w_full     = (r_cnt == w_target);
  assign ct_ready_o = reset_n & enable & ~clear & (r_state == UP_IDLE) & ~w_full;
  assign w_ct_fire  = ct_valid_i & ct_ready_o;

  assign ctw_valid_o = (r_state == UP_DRAIN);
  assign w_ctw_fire  = ctw_valid_o & ctw_ready_i;
  assign w_lane      = r_blk[(int'(WORDS) - 1 - int'(r_idx)) * WORD_W +: WORD_W];

`ifdef AES_ADAPTER_BYTESWAP_EN
  assign ctw_data_o = byte_swap(w_lane);
`else
  assign ctw_data_o = w_lane;
`endif

  assign blk_cnt_o = r_cnt[15:0];
  assign done_o    = r_done;

  // Unpack FSM: capture block in UP_IDLE, drain lanes in UP_DRAIN, count blocks.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_state <= UP_IDLE;
      r_idx   <= '0;
      r_blk   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        UP_IDLE: begin
          if (w_ct_fire) begin
            r_blk   <= ct_data_i;
            r_idx   <= '0;
            r_state <= UP_DRAIN;
          end
        end
        UP_DRAIN: begin
          if (w_ctw_fire) begin
            if (r_idx == IDX_W'(WORDS - 1)) begin
              r_idx   <= '0;
              r_state <= UP_IDLE;
              r_cnt   <= w_cnt_inc;
              r_done  <= (w_cnt_inc == w_target);
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= UP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/aes_stream_adapter.sv
// AES stream adapter top: packs plaintext words into 128-bit blocks for the AES core
// (inline packer) and unpacks ciphertext blocks into words (aes_unpacker).
// Optional feature macro: AES_ADAPTER_BYTESWAP_EN (byte-reverse each input word).
module aes_stream_adapter
  import aes_package::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [15:0]          n_blocks_i,
  aes_stream_adapter_if.slave  bus,
  output logic [15:0]          blk_cnt_o,
  output logic                 done_o
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  pk_state_t               r_pk_state;
  logic [IDX_W-1:0]        r_pk_idx;
  logic [WORD_W*WORDS-1:0] r_pk_blk;

  logic [WORD_W-1:0] w_pt_word;
  logic              w_pt_fire;

`ifdef AES_ADAPTER_BYTESWAP_EN
  assign w_pt_word = byte_swap(bus.pt_data_i);
`else
  assign w_pt_word = bus.pt_data_i;
`endif

  // Clear also blocks acceptance so no word is silently swallowed during it.
  assign bus.pt_ready_o  = reset_n & enable & ~clear & (r_pk_state == PK_FILL);
  assign w_pt_fire       = bus.pt_valid_i & bus.pt_ready_o;
  assign bus.blk_valid_o = (r_pk_state == PK_HOLD);
  assign bus.blk_data_o  = r_pk_blk;

  // Pack FSM: fill lanes 0..WORDS-1 (lane 0 in the MSBs), then hold until taken.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_pk_state <= PK_FILL;
      r_pk_idx   <= '0;
      r_pk_blk   <= '0;
    end else begin
      unique case (r_pk_state)
        PK_FILL: begin
          if (w_pt_fire) begin
            r_pk_blk[(int'(WORDS) - 1 - int'(r_pk_idx)) * WORD_W +: WORD_W] <= w_pt_word;
            if (r_pk_idx == IDX_W'(WORDS - 1)) begin
              r_pk_idx   <= '0;
              r_pk_state <= PK_HOLD;
            end else begin
              r_pk_idx <= r_pk_idx + 1'b1;
            end
          end
        end
        PK_HOLD: begin
          if (bus.blk_ready_i) begin
            r_pk_state <= PK_FILL;
          end
        end
        default: r_pk_state <= PK_FILL;
      endcase
    end
  end

  aes_unpacker #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS)
  ) u_unpacker (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .enable      (enable),
    .n_blocks_i  (n_blocks_i),
    .ct_data_i   (bus.ct_data_i),
    .ct_valid_i  (bus.ct_valid_i),
    .ct_ready_o  (bus.ct_ready_o),
    .ctw_data_o  (bus.ctw_data_o),
    .ctw_valid_o (bus.ctw_valid_o),
    .ctw_ready_i (bus.ctw_ready_i),
    .blk_cnt_o   (blk_cnt_o),
    .done_o      (done_o)
  );

endmodule

// File: doc/aes_stream_adapter.md
AES_STREAM_ADAPTER -- requirements
Module: aes_stream_adapter

Interface
REQ-001 SHALL have parameter WORD_W, default 32: streamer word width in bits.
REQ-002 SHALL have parameter WORDS, default 4: words per 128-bit AES block (WORD_W*WORDS = 128).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous active-low reset.
REQ-005 SHALL have port clear, input, 1: synchronous soft clear from controller.
REQ-006 SHALL have port enable, input, 1: stalls all acceptance when low.
REQ-007 SHALL have port n_blocks_i, input, 16: blocks per job; 0 means 65536.
REQ-008 SHALL have ports pt_data_i (input, 32), pt_valid_i (input, 1), pt_ready_o (output, 1): plaintext word stream from source streamer.
REQ-009 SHALL have ports blk_data_o (output, 128), blk_valid_o (output, 1), blk_ready_i (input, 1): packed block to AES core.
REQ-010 SHALL have ports ct_data_i (input, 128), ct_valid_i (input, 1), ct_ready_o (output, 1): ciphertext block from AES core.
REQ-011 SHALL have ports ctw_data_o (output, 32), ctw_valid_o (output, 1), ctw_ready_i (input, 1): ciphertext word stream to sink streamer.
REQ-012 SHALL have ports blk_cnt_o (output, 16) and done_o (output, 1): ciphertext blocks fully drained, and a job-complete pulse.

Function
REQ-013 SHALL transfer on any interface only in a cycle where valid and ready are both high; valid and data SHALL stay stable until transfer.
REQ-014 Packer FSM SHALL have states PK_FILL and PK_HOLD.
REQ-015 In PK_FILL, pt_ready_o = enable; each accepted word SHALL go to lane pk_idx, where lane 0 occupies bits [127:96] and lane 3 occupies bits [31:0]; pk_idx then increments.
REQ-016 On acceptance of lane WORDS-1, the FSM SHALL enter PK_HOLD and assert blk_valid_o on the next cycle; packer latency is 1 cycle after the last word.
REQ-017 In PK_HOLD, pt_ready_o SHALL be 0; on blk_valid_o&blk_ready_i the FSM SHALL return to PK_FILL with pk_idx=0.
REQ-018 Unpacker FSM SHALL have states UP_IDLE and UP_DRAIN.
REQ-019 In UP_IDLE, ct_ready_o = enable; the accepted block SHALL be registered and the FSM SHALL enter UP_DRAIN with up_idx=0.
REQ-020 In UP_DRAIN, ctw_data_o SHALL be lane up_idx (same lane order as REQ-015) with ctw_valid_o=1; up_idx SHALL increment on each transfer.
REQ-021 Transfer of lane WORDS-1 SHALL increment blk_cnt_o and return the unpacker to UP_IDLE.
REQ-022 A new ct block SHALL NOT be accepted in the same cycle the last word drains; ct_ready_o SHALL rise the following cycle.
REQ-023 done_o SHALL pulse high for exactly 1 cycle when blk_cnt_o reaches n_blocks_i, then hold; blk_cnt_o SHALL saturate at that value, and further ct blocks SHALL be refused (ct_ready_o=0) until clear.
REQ-024 Packer and unpacker SHALL operate independently and concurrently.
REQ-025 enable=0 SHALL force pt_ready_o and ct_ready_o to 0; blocks and words already held SHALL keep their valids asserted.
REQ-026 clear=1 SHALL discard partial and held blocks, return both FSMs to their idle states, and zero the indices, blk_cnt_o and done_o.

Reset
REQ-027 On reset_n=0 at a clock edge, both FSMs SHALL go idle and every output except the combinational readies SHALL be 0; readies SHALL be 0 during reset.
REQ-028 reset_n SHALL take priority over clear; reset mid-block SHALL discard the block without emitting it.

Configuration
REQ-029 When macro AES_ADAPTER_BYTESWAP_EN is defined, each 32-bit word SHALL be byte-reversed at both pack input and unpack output; when undefined, words SHALL pass unmodified.

Structure
REQ-030 The FSM state enums (pk_state_t, up_state_t) and the constants AES_BLOCK_W=128 and AES_WORD_W=32 SHALL reside in aes_package.
REQ-031 The byte-swap function SHALL reside in aes_package; sub-module aes_unpacker SHALL hold the unpack FSM, and the packer SHALL be inline.

Verification
REQ-032 Words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with blk_ready_i=1 -> blk_data_o=0x00112233_44556677_8899AABB_CCDDEEFF, blk_valid_o high 1 cycle after the 4th word.
REQ-033 blk_ready_i held 0 for 5 cycles in PK_HOLD -> pt_ready_o=0 and blk_data_o stable throughout, then return to PK_FILL.
REQ-034 ct_data_i=0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A, ctw_ready_i toggling -> words 0x69C4E0D8, 0x6A7B0430, 0xD8CDB780, 0x70B4C55A in order, blk_cnt_o=1.
REQ-035 n_blocks_i=2, two ct blocks -> done_o single-cycle pulse after the 8th word; a third ct_valid_i is refused.
REQ-036 clear after 2 plaintext words -> next 4 words form a fresh block; reset_n=0 during UP_DRAIN -> ctw_valid_o=0 the next cycle.
REQ-037 With AES_ADAPTER_BYTESWAP_EN, input 0x00112233 -> lane 0 of blk_data_o = 0x33221100.
